// File: rtl/rv_bus_pkg.sv
// ============================================================================
// Module   : rv_bus_pkg
// Brief    : Shared types and default widths for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_bus_pkg;

    localparam int c_addr_w = 32;
    localparam int c_data_w = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================================
// Module   : arb_starve_ctr
// Brief    : Saturating up-counter with synchronous clear, async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_lim = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority so a win by the starved side always restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_lim)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-requester (IFU/LSU) arbiter onto one shared memory port,
//            one transaction outstanding, LSU priority with IFU anti-starvation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import rv_bus_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w,
    parameter int DATA_W     = c_data_w,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_resp_valid_o,
    output logic [DATA_W-1:0]   ifu_resp_data_o,

    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    output logic                lsu_resp_valid_o,
    output logic [DATA_W-1:0]   lsu_resp_data_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_resp_data_i,

    output logic                stray_resp_o
);

    localparam int               c_cnt_w = $clog2(STARVE_LIM + 1);
    localparam logic [c_cnt_w-1:0] c_lim = c_cnt_w'(STARVE_LIM);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    arb_owner_e         r_owner;
    arb_owner_e         w_owner_nxt;
    arb_owner_e         w_grant;
    logic               w_req_any;
    logic               w_inc;
    logic               w_clr;
    logic [c_cnt_w-1:0] w_starve_cnt;

    arb_starve_ctr #(
        .LIMIT (STARVE_LIM),
        .CNT_W (c_cnt_w)
    ) u_starve_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_inc),
        .i_clr (w_clr),
        .o_cnt (w_starve_cnt)
    );

    assign w_req_any = ifu_req_valid_i | lsu_req_valid_i;
    assign w_grant   = (lsu_req_valid_i && !(ifu_req_valid_i && (w_starve_cnt == c_lim)))
                       ? OWN_LSU : OWN_IFU;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_IFU;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Outputs are gated by rst so they read zero for the whole reset window,
    // not just from the first clock edge onwards.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_inc            = 1'b0;
        w_clr            = 1'b0;
        ifu_req_ready_o  = 1'b0;
        lsu_req_ready_o  = 1'b0;
        ifu_resp_valid_o = 1'b0;
        ifu_resp_data_o  = '0;
        lsu_resp_valid_o = 1'b0;
        lsu_resp_data_o  = '0;
        mem_req_valid_o  = 1'b0;
        mem_addr_o       = '0;
        mem_wdata_o      = '0;
        mem_we_o         = 1'b0;
        mem_wstrb_o      = '0;
        stray_resp_o     = 1'b0;

        if (!rst) begin
            case (r_state)
                IDLE: begin
                    stray_resp_o    = mem_resp_valid_i;
                    mem_req_valid_o = w_req_any;
                    if (w_grant == OWN_LSU) begin
                        mem_addr_o  = lsu_addr_i;
                        mem_wdata_o = lsu_wdata_i;
                        mem_we_o    = lsu_we_i;
                        mem_wstrb_o = lsu_wstrb_i;
                    end else if (ifu_req_valid_i) begin
                        mem_addr_o  = ifu_addr_i;
                    end
                    if (w_req_any && mem_req_ready_i) begin
                        w_state_nxt = BUSY;
                        w_owner_nxt = w_grant;
                        if (w_grant == OWN_LSU) begin
                            lsu_req_ready_o = 1'b1;
                            w_inc           = ifu_req_valid_i;
                        end else begin
                            ifu_req_ready_o = 1'b1;
                            w_clr           = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_resp_valid_i) begin
                        w_state_nxt = IDLE;
                        if (r_owner == OWN_LSU) begin
                            lsu_resp_valid_o = 1'b1;
                            lsu_resp_data_o  = mem_resp_data_i;
                        end else begin
                            ifu_resp_valid_o = 1'b1;
                            ifu_resp_data_o  = mem_resp_data_i;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
